// File: rtl/viterbi_sched_if.sv
// viterbi_sched_if: codeword-in / decoded-word-out handshake bundle
// Ports (signals): s_valid/s_ready/s_cw codeword stream; m_valid/m_ready/m_data/m_err word stream.
// slave modport is the scheduler side, master is the source/sink side.
interface viterbi_sched_if #(
  parameter int CW_W   = 28,
  parameter int DATA_W = 14
);
  logic              s_valid;
  logic              s_ready;
  logic [CW_W-1:0]   s_cw;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_err;
  modport master (output s_valid, s_cw, m_ready, input s_ready, m_valid, m_data, m_err);
  modport slave  (input s_valid, s_cw, m_ready, output s_ready, m_valid, m_data, m_err);
endinterface

// File: rtl/viterbi_sched.sv
// viterbi_sched: buffers codewords in a FIFO and sequences one viterbi core block at a time
// Ports: clk, reset (sync, active-high); bus (slave modport: s_* codeword in, m_* decoded word out);
// dec_reset/dec_in/dec_done/dec_data core hookup; busy (FSM active or FIFO non-empty); blk_cnt (words delivered).
// Optional RUN watchdog enabled by defining VIT_WDOG_EN; otherwise m_err is tied 0.
module viterbi_sched #(
  parameter int CW_W        = 28,
  parameter int DATA_W      = 14,
  parameter int FIFO_DEPTH  = 4,
  parameter int RST_CYCLES  = 2,
  parameter int WDOG_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  viterbi_sched_if.slave    bus,
  output logic              dec_reset,
  output logic [CW_W-1:0]   dec_in,
  input  logic              dec_done,
  input  logic [DATA_W-1:0] dec_data,
  output logic              busy,
  output logic [15:0]       blk_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DRST, RUN, OUT} state_t;
  state_t            state;
  logic [CW_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [15:0]       cnt;
  logic              settle;
  logic              m_valid, m_err;
  logic [DATA_W-1:0] m_data;
  logic              push, pop, wdog_hit;
  // ready follows the registered count, so a full FIFO never accepts even while popping
  assign bus.s_ready = ~reset & (count != (AW+1)'(FIFO_DEPTH));
  assign push        = bus.s_valid & bus.s_ready;
  assign pop         = state == IDLE && count != '0;
  assign busy        = state != IDLE || count != '0;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_data;
  assign bus.m_err   = m_err;
`ifdef VIT_WDOG_EN
  assign wdog_hit = cnt == 16'(WDOG_CYCLES - 1);
`else
  assign wdog_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dec_reset <= 1'b1;
      dec_in    <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_err     <= 1'b0;
      blk_cnt   <= '0;
      cnt       <= '0;
      settle    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.s_cw;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          dec_in <= mem[rd_ptr];
          cnt    <= '0;
          state  <= DRST;
        end
        DRST: if (cnt == 16'(RST_CYCLES - 1)) begin
          dec_reset <= 1'b0;
          cnt       <= '0;
          settle    <= 1'b1;
          state     <= RUN;
        end else cnt <= cnt + 1'b1;
        // first RUN cycle ignores dec_done while the core leaves reset; done beats the watchdog
        RUN: begin
          settle <= 1'b0;
          if (!settle && dec_done) begin
            m_data    <= dec_data;
            m_err     <= 1'b0;
            m_valid   <= 1'b1;
            dec_reset <= 1'b1;
            state     <= OUT;
          end else if (wdog_hit) begin
            m_data    <= '0;
            m_err     <= 1'b1;
            m_valid   <= 1'b1;
            dec_reset <= 1'b1;
            state     <= OUT;
          end
`ifdef VIT_WDOG_EN
          else cnt <= cnt + 1'b1;
`endif
        end
        OUT: if (bus.m_ready) begin
          m_valid <= 1'b0;
          blk_cnt <= blk_cnt + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_viterbi_sched.sv
// tb_viterbi_sched: directed bench for viterbi_sched with a stub core (data = cw[27:14]^cw[13:0])
module tb_viterbi_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_reset, busy;
  logic [27:0] dec_in;
  logic        dec_done;
  logic [13:0] dec_data;
  logic [15:0] blk_cnt;
  logic [3:0]  ccnt;
  logic        hang = 1'b0;
  int          n_chk = 0, n_fail = 0, viol = 0;
  logic [13:0] out_d[$];
  logic        out_e[$];
  logic [27:0] prev_in;
  logic        prev_rst;

  viterbi_sched_if #(.CW_W(28), .DATA_W(14)) bus ();

  viterbi_sched #(.WDOG_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dec_reset(dec_reset), .dec_in(dec_in),
    .dec_done(dec_done), .dec_data(dec_data), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] gold(input logic [27:0] c);
    return c[27:14] ^ c[13:0];
  endfunction

  always @(posedge clk) begin
    if (dec_reset) begin
      ccnt <= '0; dec_done <= 1'b0; dec_data <= 14'h2AAA;
    end else if (!hang && ccnt == 4'd3) begin
      dec_done <= 1'b1; dec_data <= gold(dec_in);
    end else if (!dec_done) ccnt <= ccnt + 1'b1;
  end

  always @(posedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      out_d.push_back(bus.m_data);
      out_e.push_back(bus.m_err);
    end
    if (prev_rst === 1'b0 && dec_reset === 1'b0 && dec_in !== prev_in) viol++;
    prev_in  <= dec_in;
    prev_rst <= dec_reset;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [27:0] c);
    int i = 0;
    bus.s_valid = 1'b1; bus.s_cw = c;
    while (!bus.s_ready && i < 200) begin cyc(); i++; end
    n_chk++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL push_timeout: s_ready %b required 1", bus.s_ready); end
    cyc();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int i = 0;
    while (out_d.size() < n && i < 1000) begin cyc(); i++; end
    n_chk++; if (out_d.size() < n) begin n_fail++; $display("FAIL wait_out: got %0d words required %0d", out_d.size(), n); end
  endtask

  task automatic clear_out();
    out_d.delete(); out_e.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.s_valid = 1'b0; bus.s_cw = '0; bus.m_ready = 1'b0;
    cyc(); cyc();
    n_chk++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b required 0", bus.s_ready); end
    n_chk++; if (dec_reset !== 1'b1) begin n_fail++; $display("FAIL rst_dec_reset: got %b required 1", dec_reset); end
    n_chk++; if (dec_in !== 28'h0) begin n_fail++; $display("FAIL rst_dec_in: got %h required 0", dec_in); end
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b required 0", bus.m_valid); end
    n_chk++; if (bus.m_data !== 14'h0) begin n_fail++; $display("FAIL rst_m_data: got %h required 0", bus.m_data); end
    n_chk++; if (bus.m_err !== 1'b0) begin n_fail++; $display("FAIL rst_m_err: got %b required 0", bus.m_err); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_chk++; if (blk_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_blk_cnt: got %h required 0", blk_cnt); end
    reset = 1'b0; #1;
    n_chk++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_s_ready: got %b required 1", bus.s_ready); end
  endtask

  task automatic test_single();
    clear_out(); bus.m_ready = 1'b1;
    push(28'hE2FBE2C);
    n_chk++; if (dec_reset !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_t1: dec_reset %b busy %b required 1 1", dec_reset, busy); end
    cyc();
    n_chk++; if (dec_in !== 28'hE2FBE2C || dec_reset !== 1'b1) begin n_fail++; $display("FAIL single_t2: dec_in %h dec_reset %b required e2fbe2c 1", dec_in, dec_reset); end
    cyc();
    n_chk++; if (dec_reset !== 1'b1) begin n_fail++; $display("FAIL single_t3_dec_reset: got %b required 1", dec_reset); end
    cyc();
    n_chk++; if (dec_reset !== 1'b0) begin n_fail++; $display("FAIL single_t4_dec_reset: got %b required 0", dec_reset); end
    wait_out(1);
    n_chk++; if (out_d.size() < 1 || out_d[0] !== 14'h0692) begin n_fail++; $display("FAIL single_data: got %h required 0692", out_d.size() ? out_d[0] : 14'h0); end
    n_chk++; if (out_e.size() < 1 || out_e[0] !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b required 0", out_e.size() ? out_e[0] : 1'bx); end
    n_chk++; if (blk_cnt !== 16'd1) begin n_fail++; $display("FAIL single_blk_cnt: got %0d required 1", blk_cnt); end
    repeat (10) cyc();
    n_chk++; if (out_d.size() != 1 || bus.m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_once: words %0d m_valid %b busy %b required 1 0 0", out_d.size(), bus.m_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [27:0] cws [3];
    int v0 = viol;
    cws = '{28'hE2FBE2C, 28'h522148B, 28'h0D9F88B};
    clear_out(); bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(cws[i]);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (out_d.size() <= i || out_d[i] !== gold(cws[i])) begin n_fail++; $display("FAIL b2b_word%0d: got %h required %h", i, out_d.size() > i ? out_d[i] : 14'h0, gold(cws[i])); end
    end
    n_chk++; if (viol !== v0) begin n_fail++; $display("FAIL b2b_dec_in_stable: changes %0d required %0d", viol, v0); end
    n_chk++; if (blk_cnt !== 16'd4) begin n_fail++; $display("FAIL b2b_blk_cnt: got %0d required 4", blk_cnt); end
  endtask

  task automatic test_full();
    logic [27:0] cws [6];
    int i = 0;
    cws = '{28'h1234567, 28'hABCDEF0, 28'h0F0F0F0, 28'hFFFFFFF, 28'h5A5A5A5, 28'h7654321};
    clear_out(); bus.m_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(cws[k]);
    bus.s_valid = 1'b1; bus.s_cw = cws[5];
    repeat (10) cyc();
    n_chk++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL full_s_ready: got %b required 0", bus.s_ready); end
    n_chk++; if (bus.m_valid !== 1'b1 || bus.m_data !== gold(cws[0])) begin n_fail++; $display("FAIL full_stall_out: m_valid %b m_data %h required 1 %h", bus.m_valid, bus.m_data, gold(cws[0])); end
    n_chk++; if (busy !== 1'b1 || out_d.size() != 0) begin n_fail++; $display("FAIL full_busy: busy %b words %0d required 1 0", busy, out_d.size()); end
    repeat (5) cyc();
    n_chk++; if (bus.m_data !== gold(cws[0]) || bus.m_err !== 1'b0 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: m_data %h m_err %b s_ready %b required %h 0 0", bus.m_data, bus.m_err, bus.s_ready, gold(cws[0])); end
    bus.m_ready = 1'b1;
    while (!bus.s_ready && i < 100) begin cyc(); i++; end
    n_chk++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL full_release: s_ready %b required 1", bus.s_ready); end
    cyc();
    bus.s_valid = 1'b0;
    wait_out(6);
    for (int k = 0; k < 6; k++) begin
      n_chk++; if (out_d.size() <= k || out_d[k] !== gold(cws[k])) begin n_fail++; $display("FAIL full_word%0d: got %h required %h", k, out_d.size() > k ? out_d[k] : 14'h0, gold(cws[k])); end
    end
    n_chk++; if (blk_cnt !== 16'd10) begin n_fail++; $display("FAIL full_blk_cnt: got %0d required 10", blk_cnt); end
  endtask

  task automatic test_zero();
    clear_out(); bus.m_ready = 1'b1;
    push(28'h0);
    wait_out(1);
    n_chk++; if (out_d.size() < 1 || out_d[0] !== 14'h0000 || out_e[0] !== 1'b0) begin n_fail++; $display("FAIL zero_word: got %h err %b required 0000 0", out_d.size() ? out_d[0] : 14'h3FFF, out_e.size() ? out_e[0] : 1'bx); end
    n_chk++; if (blk_cnt !== 16'd11) begin n_fail++; $display("FAIL zero_blk_cnt: got %0d required 11", blk_cnt); end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    clear_out(); bus.m_ready = 1'b1;
    push(28'h1111111); push(28'h2222222); push(28'h3333333);
    while (dec_reset && i < 50) begin cyc(); i++; end
    n_chk++; if (dec_reset !== 1'b0) begin n_fail++; $display("FAIL mid_reach_run: dec_reset %b required 0", dec_reset); end
    reset = 1'b1;
    cyc();
    n_chk++; if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_clear: m_valid %b busy %b required 0 0", bus.m_valid, busy); end
    n_chk++; if (dec_reset !== 1'b1 || blk_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_core: dec_reset %b blk_cnt %0d required 1 0", dec_reset, blk_cnt); end
    reset = 1'b0;
    repeat (60) cyc();
    n_chk++; if (out_d.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_stale: words %0d busy %b required 0 0", out_d.size(), busy); end
  endtask

`ifdef VIT_WDOG_EN
  task automatic test_wdog();
    int i = 0, n = 0;
    clear_out(); bus.m_ready = 1'b0; hang = 1'b1;
    push(28'h1234567);
    while (dec_reset && i < 50) begin cyc(); i++; end
    while (!bus.m_valid && n < 100) begin n++; cyc(); end
    n_chk++; if (n != 8) begin n_fail++; $display("FAIL wdog_run_cycles: got %0d required 8", n); end
    n_chk++; if (bus.m_valid !== 1'b1 || bus.m_err !== 1'b1 || bus.m_data !== 14'h0) begin n_fail++; $display("FAIL wdog_abort: m_valid %b m_err %b m_data %h required 1 1 0000", bus.m_valid, bus.m_err, bus.m_data); end
    hang = 1'b0; bus.m_ready = 1'b1;
    wait_out(1);
    clear_out();
    push(28'hE2FBE2C);
    wait_out(1);
    n_chk++; if (out_d.size() < 1 || out_d[0] !== 14'h0692 || out_e[0] !== 1'b0) begin n_fail++; $display("FAIL wdog_recover: got %h err %b required 0692 0", out_d.size() ? out_d[0] : 14'h0, out_e.size() ? out_e[0] : 1'bx); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_zero();
    test_reset_mid();
`ifdef VIT_WDOG_EN
    test_wdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
